imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 141 ++++++++++++++
 tb/tb_imm_extend_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate decoder feeding a 2-entry FIFO.
// Decoded {imm, fmt, illegal} are queued and presented from registers.
module imm_extend_pipe #(
    parameter int DATA_W   = 64,
    parameter int BR_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic [2:0]        fmt,
    output logic              illegal,
    output logic [7:0]        illegal_cnt
);

    localparam int BR_SH = (BR_SHIFT == 1) ? 2 : 0;

    logic [DATA_W-1:0] dec_imm_s;
    logic [2:0]        dec_fmt_s;
    logic              dec_ill_s;

    logic [DATA_W-1:0] mem_imm_r [2];
    logic [2:0]        mem_fmt_r [2];
    logic              mem_ill_r [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;

    logic [DATA_W-1:0] imm_r;
    logic [2:0]        fmt_r;
    logic              illegal_r;
    logic              out_valid_r;
    logic [7:0]        illegal_cnt_r;

    logic              push_s;
    logic              pop_s;
    logic [1:0]        count_nxt_s;
    logic              rd_nxt_s;
    logic [DATA_W-1:0] head_imm_s;
    logic [2:0]        head_fmt_s;
    logic              head_ill_s;

    // Priority decode of the incoming instruction word.
    always_comb begin
        dec_imm_s = '0;
        dec_fmt_s = 3'd0;
        dec_ill_s = 1'b0;
        if (instr[31:26] == 6'b000101) begin
            dec_fmt_s = 3'd1;
            dec_imm_s = DATA_W'($signed(instr[25:0])) << BR_SH;
        end else if (instr[31:25] == 7'b1011010) begin
            dec_fmt_s = 3'd2;
            dec_imm_s = DATA_W'($signed(instr[23:5])) << BR_SH;
        end else if ((instr[31:21] == 11'b11111000010) || (instr[31:21] == 11'b11111000000)) begin
            dec_fmt_s = 3'd3;
            dec_imm_s = DATA_W'($signed(instr[20:12]));
        end else if ((instr[31:22] == 10'b1001000100) || (instr[31:22] == 10'b1101000100)) begin
            dec_fmt_s = 3'd4;
            dec_imm_s = DATA_W'(instr[21:10]);
        end else if ((instr[31:23] == 9'b110100101) || (instr[31:23] == 9'b111100101)) begin
            // Halfword shifts past DATA_W-1 drop out naturally.
            dec_fmt_s = 3'd5;
            dec_imm_s = DATA_W'(instr[20:5]) << {instr[22:21], 4'd0};
        end else begin
            dec_ill_s = 1'b1;
        end
    end

    assign in_ready = (count_r < 2'd2) && !reset;
    assign push_s   = in_valid && in_ready;
    assign pop_s    = out_valid_r && out_ready;

    // Next occupancy, read pointer and the entry that will sit at the head.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        rd_nxt_s = pop_s ? ~rd_ptr_r : rd_ptr_r;
        if (count_nxt_s == 2'd0) begin
            head_imm_s = '0;
            head_fmt_s = 3'd0;
            head_ill_s = 1'b0;
        end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_imm_s = dec_imm_s;
            head_fmt_s = dec_fmt_s;
            head_ill_s = dec_ill_s;
        end else begin
            head_imm_s = mem_imm_r[rd_nxt_s];
            head_fmt_s = mem_fmt_r[rd_nxt_s];
            head_ill_s = mem_ill_r[rd_nxt_s];
        end
    end

    // FIFO storage, pointers, registered head copy and illegal counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_imm_r[i] <= '0;
                mem_fmt_r[i] <= 3'd0;
                mem_ill_r[i] <= 1'b0;
            end
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
            imm_r         <= '0;
            fmt_r         <= 3'd0;
            illegal_r     <= 1'b0;
            out_valid_r   <= 1'b0;
            illegal_cnt_r <= 8'd0;
        end else begin
            if (push_s) begin
                mem_imm_r[wr_ptr_r] <= dec_imm_s;
                mem_fmt_r[wr_ptr_r] <= dec_fmt_s;
                mem_ill_r[wr_ptr_r] <= dec_ill_s;
                wr_ptr_r            <= ~wr_ptr_r;
            end
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= count_nxt_s;
            imm_r       <= head_imm_s;
            fmt_r       <= head_fmt_s;
            illegal_r   <= head_ill_s;
            out_valid_r <= (count_nxt_s != 2'd0);
            if (push_s && dec_ill_s && (illegal_cnt_r != 8'hFF)) begin
                illegal_cnt_r <= illegal_cnt_r + 8'd1;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign imm         = imm_r;
    assign fmt         = fmt_r;
    assign illegal     = illegal_r;
    assign illegal_cnt = illegal_cnt_r;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: driver queues hand-computed results,
// a negedge monitor compares whatever the DUT presents.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    imm_extend_pipe #(.DATA_W(64), .BR_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_vec(input logic [31:0] ins, input logic [63:0] e_imm,
                            input logic [2:0] e_fmt, input logic e_ill);
        bit done = 0;
        in_valid = 1'b1;
        instr    = ins;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{imm: e_imm, fmt: e_fmt, ill: e_ill});
                if (e_ill && exp_cnt < 255) exp_cnt++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_vectors();
        push_vec(32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1, 1'b0);
        push_vec(32'h1400_0001, 64'h0000_0000_0000_0004, 3'd1, 1'b0);
        push_vec(32'h15FF_FFFF, 64'h0000_0000_07FF_FFFC, 3'd1, 1'b0);
        push_vec(32'hB400_0040, 64'h0000_0000_0000_0008, 3'd2, 1'b0);
        push_vec(32'hB5FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        push_vec(32'hF85F_8000, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
        push_vec(32'hF800_0000, 64'h0000_0000_0000_0000, 3'd3, 1'b0);
        push_vec(32'hF800_F000, 64'h0000_0000_0000_000F, 3'd3, 1'b0);
        push_vec(32'h9100_3C00, 64'h0000_0000_0000_000F, 3'd4, 1'b0);
        push_vec(32'hD13F_FC00, 64'h0000_0000_0000_0FFF, 3'd4, 1'b0);
        push_vec(32'hD2F5_79A0, 64'hABCD_0000_0000_0000, 3'd5, 1'b0);
        push_vec(32'hF280_0020, 64'h0000_0000_0000_0001, 3'd5, 1'b0);
        push_vec(32'hD2A0_0020, 64'h0000_0000_0001_0000, 3'd5, 1'b0);
        push_vec(32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 3'd0, 1'b1);
        push_vec(32'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare the head against the scoreboard, pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = sb[0];
                    check("out_imm", imm, e.imm);
                    check("out_fmt", 64'(fmt), 64'(e.fmt));
                    check("out_illegal", 64'(illegal), 64'(e.ill));
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                check("idle_zero", {imm[60:0], fmt}, 64'd0);
                check("idle_illegal", 64'(illegal), 64'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency 1, no bypass from an empty FIFO.
        in_valid = 1'b1;
        instr    = 32'hF85F_8000;
        @(negedge clk);
        check("no_bypass", 64'(out_valid), 64'd0);
        check("lat_in_ready", 64'(in_ready), 64'd1);
        sb.push_back('{imm: 64'hFFFF_FFFF_FFFF_FFF8, fmt: 3'd3, ill: 1'b0});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("latency1", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        run_vectors();
        drain();
        @(negedge clk);
        check("illegal_cnt_vec", 64'(illegal_cnt), 64'(exp_cnt));
        @(posedge clk);
        #1;

        // Same vectors under irregular consumer backpressure.
        fork
            run_vectors();
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk);
                    #1 out_ready = ((k % 3) != 1) && ((k % 7) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("illegal_cnt_bp", 64'(illegal_cnt), 64'(exp_cnt));
        @(posedge clk);
        #1;

        // A, B accepted, C held until the consumer resumes.
        out_ready = 1'b0;
        push_vec(32'h9100_3C00, 64'h0000_0000_0000_000F, 3'd4, 1'b0);
        push_vec(32'h1400_0001, 64'h0000_0000_0000_0004, 3'd1, 1'b0);
        in_valid = 1'b1;
        instr    = 32'hD2F5_79A0;
        @(negedge clk);
        check("bp_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_still_held", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_vec(32'hD2F5_79A0, 64'hABCD_0000_0000_0000, 3'd5, 1'b0);
        drain();

        // Saturation of the illegal counter.
        for (int k = 0; k < 300; k++) push_vec(32'h0000_0000, 64'd0, 3'd0, 1'b1);
        drain();
        @(negedge clk);
        check("illegal_cnt_sat", 64'(illegal_cnt), 64'd255);
        check("illegal_cnt_model", 64'(illegal_cnt), 64'(exp_cnt));
        @(posedge clk);
        #1;

        // Reset with two entries held.
        out_ready = 1'b0;
        push_vec(32'hFFFF_FFFF, 64'd0, 3'd0, 1'b1);
        push_vec(32'hF85F_8000, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        sb.delete();
        exp_cnt = 0;
        reset   = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        check("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        push_vec(32'hB5FF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
